// File: rtl/control_sequencer.sv
// Instruction-fetch/ALU control sequencer: RESET, T0..T5 and HALT, with
// registered Moore strobes decoded from the next state and the latched opcode.
module control_sequencer (
  input  logic        i_clk,
  input  logic        i_clear,
  input  logic [31:0] i_ir,
  input  logic        i_mem_ready,
  input  logic        i_stop,
  output logic        o_pc_out,
  output logic        o_mdr_out,
  output logic        o_zlo_out,
  output logic        o_pc_in,
  output logic        o_mdr_in,
  output logic        o_mar_in,
  output logic        o_ir_in,
  output logic        o_y_in,
  output logic        o_zlo_in,
  output logic        o_inc_pc,
  output logic        o_read,
  output logic        o_gra,
  output logic        o_grb,
  output logic        o_grc,
  output logic        o_r_in,
  output logic        o_r_out,
  output logic [4:0]  o_control,
  output logic        o_run,
  output logic        o_illegal
);

  typedef enum logic [2:0] {
    S_RESET = 3'd0,
    S_T0    = 3'd1,
    S_T1    = 3'd2,
    S_T2    = 3'd3,
    S_T3    = 3'd4,
    S_T4    = 3'd5,
    S_T5    = 3'd6,
    S_HALT  = 3'd7
  } state_t;

  typedef struct packed {
    logic       pc_out;
    logic       mdr_out;
    logic       zlo_out;
    logic       pc_in;
    logic       mdr_in;
    logic       mar_in;
    logic       ir_in;
    logic       y_in;
    logic       zlo_in;
    logic       inc_pc;
    logic       read;
    logic       gra;
    logic       grb;
    logic       grc;
    logic       r_in;
    logic       r_out;
    logic [4:0] control;
    logic       run;
  } ctrl_t;

  localparam logic [4:0] OP_ALU_LO = 5'd3;
  localparam logic [4:0] OP_ALU_HI = 5'd10;
  localparam logic [4:0] OP_HALT   = 5'd27;

  function automatic logic is_alu_op(input logic [4:0] op);
    return (op >= OP_ALU_LO) && (op <= OP_ALU_HI);
  endfunction

  function automatic ctrl_t decode(input state_t st, input logic [4:0] op);
    ctrl_t c;
    c = '0;
    case (st)
      S_T0: begin
        c.pc_out = 1'b1; c.mar_in = 1'b1; c.inc_pc = 1'b1; c.zlo_in = 1'b1; c.run = 1'b1;
      end
      S_T1: begin
        c.zlo_out = 1'b1; c.pc_in = 1'b1; c.read = 1'b1; c.mdr_in = 1'b1; c.run = 1'b1;
      end
      S_T2: begin
        c.mdr_out = 1'b1; c.ir_in = 1'b1; c.run = 1'b1;
      end
      S_T3: begin
        c.run = 1'b1;
        // A halt instruction touches no registers on its way out
        if (op != OP_HALT) begin
          c.grb = 1'b1; c.r_out = 1'b1; c.y_in = 1'b1;
        end else begin
          c.grb = 1'b0; c.r_out = 1'b0; c.y_in = 1'b0;
        end
      end
      S_T4: begin
        c.grc = 1'b1; c.r_out = 1'b1; c.zlo_in = 1'b1; c.run = 1'b1;
        c.control = op - 5'd1;
      end
      S_T5: begin
        c.zlo_out = 1'b1; c.gra = 1'b1; c.r_in = 1'b1; c.run = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  state_t     r_state;
  state_t     w_state_next;
  logic [4:0] r_opcode;
  logic [4:0] w_opcode_next;
  logic       r_stop_pend;
  logic       w_stop_pend_next;
  logic       r_illegal;
  logic       w_illegal_next;
  ctrl_t      r_ctrl;
  ctrl_t      w_ctrl_next;
  logic       w_in_seq;
  logic       w_unused_ir;

  assign w_in_seq    = (r_state != S_RESET) && (r_state != S_HALT);
  assign w_unused_ir = ^i_ir[26:0];

  // Next-state, opcode capture, stop-pending and sticky illegal logic
  always_comb begin
    w_state_next     = r_state;
    w_opcode_next    = r_opcode;
    w_illegal_next   = r_illegal;
    w_stop_pend_next = r_stop_pend;
    case (r_state)
      S_RESET: w_state_next = S_T0;
      S_T0:    w_state_next = S_T1;
      S_T1: begin
        if (i_mem_ready) begin
          w_state_next = S_T2;
        end else begin
          w_state_next = S_T1;
        end
      end
      S_T2: begin
        w_state_next  = S_T3;
        w_opcode_next = i_ir[31:27];
      end
      S_T3: begin
        if (is_alu_op(r_opcode)) begin
          w_state_next = S_T4;
        end else if (r_opcode == OP_HALT) begin
          w_state_next = S_HALT;
        end else begin
          w_state_next   = S_HALT;
          w_illegal_next = 1'b1;
        end
      end
      S_T4: w_state_next = S_T5;
      S_T5: begin
        // A stop raised in T5 itself still ends the run at this boundary
        if (r_stop_pend || i_stop) begin
          w_state_next = S_HALT;
        end else begin
          w_state_next = S_T0;
        end
      end
      S_HALT:  w_state_next = S_HALT;
      default: w_state_next = S_RESET;
    endcase
    if (w_state_next == S_HALT) begin
      w_stop_pend_next = 1'b0;
    end else begin
      w_stop_pend_next = r_stop_pend | (w_in_seq & i_stop);
    end
    w_ctrl_next = decode(w_state_next, w_opcode_next);
  end

  // FSM state register
  always_ff @(posedge i_clk) begin
    if (i_clear) begin
      r_state <= S_RESET;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Opcode, flags and registered output strobes
  always_ff @(posedge i_clk) begin
    if (i_clear) begin
      r_opcode    <= 5'd0;
      r_stop_pend <= 1'b0;
      r_illegal   <= 1'b0;
      r_ctrl      <= '0;
    end else begin
      r_opcode    <= w_opcode_next;
      r_stop_pend <= w_stop_pend_next;
      r_illegal   <= w_illegal_next;
      r_ctrl      <= w_ctrl_next;
    end
  end

  assign o_pc_out  = r_ctrl.pc_out;
  assign o_mdr_out = r_ctrl.mdr_out;
  assign o_zlo_out = r_ctrl.zlo_out;
  assign o_pc_in   = r_ctrl.pc_in;
  assign o_mdr_in  = r_ctrl.mdr_in;
  assign o_mar_in  = r_ctrl.mar_in;
  assign o_ir_in   = r_ctrl.ir_in;
  assign o_y_in    = r_ctrl.y_in;
  assign o_zlo_in  = r_ctrl.zlo_in;
  assign o_inc_pc  = r_ctrl.inc_pc;
  assign o_read    = r_ctrl.read;
  assign o_gra     = r_ctrl.gra;
  assign o_grb     = r_ctrl.grb;
  assign o_grc     = r_ctrl.grc;
  assign o_r_in    = r_ctrl.r_in;
  assign o_r_out   = r_ctrl.r_out;
  assign o_control = r_ctrl.control;
  assign o_run     = r_ctrl.run;
  assign o_illegal = r_illegal;

endmodule

// File: tb/tb_control_sequencer.sv
// Randomized bench for control_sequencer: a phase-level reference model is
// checked every cycle, with directed scenarios pinned by literal expectations.
module tb_control_sequencer;

  logic        clk = 1'b0;
  logic        clear, mem_ready, stop;
  logic [31:0] ir;
  logic pc_out, mdr_out, zlo_out, pc_in, mdr_in, mar_in, ir_in, y_in, zlo_in;
  logic inc_pc, read, gra, grb, grc, r_in, r_out, run, illegal;
  logic [4:0] control;

  always #5 clk = ~clk;

  control_sequencer dut (
    .i_clk(clk), .i_clear(clear), .i_ir(ir), .i_mem_ready(mem_ready), .i_stop(stop),
    .o_pc_out(pc_out), .o_mdr_out(mdr_out), .o_zlo_out(zlo_out), .o_pc_in(pc_in),
    .o_mdr_in(mdr_in), .o_mar_in(mar_in), .o_ir_in(ir_in), .o_y_in(y_in),
    .o_zlo_in(zlo_in), .o_inc_pc(inc_pc), .o_read(read), .o_gra(gra), .o_grb(grb),
    .o_grc(grc), .o_r_in(r_in), .o_r_out(r_out), .o_control(control), .o_run(run),
    .o_illegal(illegal)
  );

  wire [22:0] dut_vec = {pc_out, mdr_out, zlo_out, pc_in, mdr_in, mar_in, ir_in, y_in,
                         zlo_in, inc_pc, read, gra, grb, grc, r_in, r_out, control, run, illegal};

  // Strobe bit positions inside the 16-bit strobe field
  localparam int B_PC_OUT = 15, B_MDR_OUT = 14, B_ZLO_OUT = 13, B_PC_IN = 12;
  localparam int B_MDR_IN = 11, B_MAR_IN = 10, B_IR_IN = 9, B_Y_IN = 8;
  localparam int B_ZLO_IN = 7, B_INC_PC = 6, B_READ = 5, B_GRA = 4;
  localparam int B_GRB = 3, B_GRC = 2, B_R_IN = 1, B_R_OUT = 0;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: ph = -1 reset, 0..5 for T0..T5, 6 halted
  int         ph;
  logic [4:0] mop;
  bit         mstop, mill;

  function automatic logic [22:0] expect_vec(input int p, input logic [4:0] op, input bit ill);
    logic [15:0] s;
    logic [4:0]  c;
    logic        r;
    s = 16'd0; c = 5'd0; r = 1'b0;
    case (p)
      0: begin s[B_PC_OUT] = 1'b1; s[B_MAR_IN] = 1'b1; s[B_INC_PC] = 1'b1; s[B_ZLO_IN] = 1'b1; end
      1: begin s[B_ZLO_OUT] = 1'b1; s[B_PC_IN] = 1'b1; s[B_READ] = 1'b1; s[B_MDR_IN] = 1'b1; end
      2: begin s[B_MDR_OUT] = 1'b1; s[B_IR_IN] = 1'b1; end
      3: if (op != 5'd27) begin s[B_GRB] = 1'b1; s[B_R_OUT] = 1'b1; s[B_Y_IN] = 1'b1; end
      4: begin s[B_GRC] = 1'b1; s[B_R_OUT] = 1'b1; s[B_ZLO_IN] = 1'b1; c = op - 5'd1; end
      5: begin s[B_ZLO_OUT] = 1'b1; s[B_GRA] = 1'b1; s[B_R_IN] = 1'b1; end
      default: s = 16'd0;
    endcase
    r = (p >= 0) && (p <= 5);
    return {s, c, r, ill};
  endfunction

  task automatic model_update();
    int prev;
    prev = ph;
    if (clear) begin
      ph = -1; mop = 5'd0; mstop = 1'b0; mill = 1'b0;
    end else begin
      if (prev >= 0 && prev <= 5 && stop) mstop = 1'b1;
      case (prev)
        -1: ph = 0;
        0:  ph = 1;
        1:  ph = mem_ready ? 2 : 1;
        2:  begin mop = ir[31:27]; ph = 3; end
        3:  begin
              if (mop >= 5'd3 && mop <= 5'd10) ph = 4;
              else begin ph = 6; if (mop != 5'd27) mill = 1'b1; end
            end
        4:  ph = 5;
        5:  ph = mstop ? 6 : 0;
        6:  ph = 6;
        default: ph = -1;
      endcase
      if (ph == 6) mstop = 1'b0;
    end
  endtask

  task automatic step();
    logic [22:0] exp_v;
    @(posedge clk);
    model_update();
    #1;
    n_vec++;
    exp_v = expect_vec(ph, mop, mill);
    if (dut_vec !== exp_v) begin
      n_err++;
      $display("FAIL model_cycle %0d: got=%h exp=%h phase=%0d", n_vec, dut_vec, exp_v, ph);
    end
    if ($countones({pc_out, mdr_out, zlo_out, r_out}) > 1) begin
      n_err++;
      $display("FAIL bus_exclusive cycle %0d: drivers=%b required at most one",
               n_vec, {pc_out, mdr_out, zlo_out, r_out});
    end
  endtask

  task automatic check_lit(input string name, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h exp=%0h", name, act, exp);
    end
  endtask

  initial begin
    int t1_cnt;
    int halt_cnt;
    logic [31:0] rnd;
    logic [4:0]  op;
    clear = 1'b1; mem_ready = 1'b1; stop = 1'b0; ir = 32'h2800_0000;
    ph = -1; mop = 5'd0; mstop = 1'b0; mill = 1'b0;

    // Reset then one plain shr instruction
    step(); step();
    check_lit("reset_outputs", 32'(dut_vec), 32'd0);
    clear = 1'b0;
    step(); check_lit("t0_pc_out", 32'(pc_out), 32'd1); check_lit("t0_mar_in", 32'(mar_in), 32'd1);
    step(); check_lit("t1_read", 32'(read), 32'd1);
    step(); check_lit("t2_ir_in", 32'(ir_in), 32'd1);
    step(); check_lit("t3_control", 32'(control), 32'd0);
    step(); check_lit("t4_control", 32'(control), 32'h04); check_lit("t4_grc", 32'(grc), 32'd1);
    step(); check_lit("t5_r_in", 32'(r_in), 32'd1); check_lit("t5_control", 32'(control), 32'd0);
    step(); check_lit("t0_repeat", 32'(pc_out), 32'd1);

    // Memory wait: three not-ready edges keep T1 for four cycles
    mem_ready = 1'b0; t1_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (read) t1_cnt++;
    end
    mem_ready = 1'b1;
    step(); check_lit("t1_wait_cycles", 32'(t1_cnt), 32'd4); check_lit("t2_after_wait", 32'(ir_in), 32'd1);
    step(); step(); step(); step();

    // Illegal opcode 11111 halts with a sticky flag
    ir = 32'hF800_0000;
    step(); step(); step();
    step(); check_lit("illegal_set", 32'(illegal), 32'd1); check_lit("illegal_run", 32'(run), 32'd0);
    for (int i = 0; i < 10; i++) step();
    check_lit("illegal_hold", 32'({illegal, run}), 32'h2);
    clear = 1'b1;
    step(); check_lit("clear_illegal", 32'(illegal), 32'd0); check_lit("clear_outputs", 32'(dut_vec), 32'd0);
    clear = 1'b0;
    step(); check_lit("t0_after_clear", 32'(pc_out), 32'd1);

    // One-cycle stop in T2 finishes the instruction, then halts
    ir = 32'h2800_0000;
    step(); step();
    stop = 1'b1;
    step();
    stop = 1'b0;
    step(); check_lit("stop_t4_control", 32'(control), 32'h04);
    step(); check_lit("stop_t5_gra", 32'(gra), 32'd1);
    step(); check_lit("stop_halt_run", 32'(run), 32'd0); check_lit("stop_no_t0", 32'(pc_out), 32'd0);
    clear = 1'b1; step(); clear = 1'b0; step();

    // Halt opcode: silent T3, no illegal flag
    ir = 32'hD800_0000;
    step(); step();
    step(); check_lit("halt_t3_strobes", 32'({grb, r_out, y_in}), 32'd0); check_lit("halt_t3_run", 32'(run), 32'd1);
    step(); check_lit("halt_illegal", 32'(illegal), 32'd0); check_lit("halt_run", 32'(run), 32'd0);
    clear = 1'b1; step(); clear = 1'b0; step();

    // Clear during T4
    ir = 32'h2800_0000;
    step(); step(); step();
    step(); check_lit("pre_clear_t4", 32'(control), 32'h04);
    clear = 1'b1;
    step(); check_lit("clear_t4_outputs", 32'(dut_vec), 32'd0); check_lit("clear_t4_control", 32'(control), 32'd0);
    clear = 1'b0;

    // Randomized traffic
    halt_cnt = 0;
    for (int i = 0; i < 4000; i++) begin
      halt_cnt = (ph == 6) ? halt_cnt + 1 : 0;
      clear = ($urandom_range(63) == 0) || (halt_cnt > 4);
      mem_ready = ($urandom_range(3) != 0);
      stop = ($urandom_range(31) == 0);
      if ($urandom_range(3) == 0) begin
        rnd = $urandom();
        case ($urandom_range(9))
          0, 1, 2, 3, 4, 5: op = 5'(3 + $urandom_range(7));
          6:       op = 5'd27;
          default: op = rnd[31:27];
        endcase
        ir = {op, rnd[26:0]};
      end
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
